aes_kinv: RTL
=============

# aes_kinv

Sequential inverse-order AES key scheduler for the decryption datapath. It accepts a cipher key and runs the FIPS-197 key expansion forward through a sliding Nk-word window to reach the last round key. It then runs the recurrence backwards to deliver round keys Nr, Nr-1, … 0, one 128-bit key per handshake, to the inverse-cipher round logic. No 4·(Nr+1)-word expanded-key storage is used; the only state is the Nk-word window plus one output register.

## Interface
- NK, default 8, key length in 32-bit words: 4, 6 or 8. Nb = 4 is fixed; Nr = NK+6.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- key_valid  in  1  key offered.
- key_ready  out  1  block idle and able to accept a key.
- key  in  256  cipher key. Key byte 0 is [255:248]. Only the upper 32·NK bits are used.
- SBox  in  8 x [0:255]  forward S-box table, same form as used by the forward expansion.
- RCon  in  8 x [0:15]  round constants. RCon[1]=8'h01, RCon[2]=8'h02, …
- rk_valid  out  1  round key on rk is valid.
- rk_ready  in  1  consumer accepts rk.
- rk  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
- rk_round  out  4  round index r of rk.
- rk_last  out  1  high while rk_valid and r = 0.

## Operation
- Word function g(j, x), where j is the index of the word being produced or undone:
  - j%NK==0: SubWord(RotWord(x)) ^ {RCon[j/NK],24'h0}.
  - NK==8 and j%NK==4: SubWord(x).
  - Otherwise: x.
- Window W[0..NK-1] of 32-bit words; W[NK-1] is the highest-indexed word held. Word index counter j is 6 bits; maximum index is 59.
- States:
  - IDLE: key_ready=1.
    - On key_valid&&key_ready: W[k] = key word k, j = NK; go to FWD.
  - FWD: each cycle compute w[j] = W[0] ^ g(j, W[NK-1]); shift the window down, with the new word entering W[NK-1]; j++.
    - After j = 4(Nr+1)-1 is produced, go to BWD with j = 4Nr+3, the top word index.
  - BWD: one step per cycle emits the top word W[NK-1] = w[j] into a 4-word collector; j--.
    - If the emitted index is ≥ NK: compute w[j-NK] = W[NK-1] ^ g(j, W[NK-2]), shift the window up, and insert the new word at W[0].
    - Otherwise: shift only.
    - When the collector completes a group (emitted index %4 == 0), load rk, rk_round = emitted index/4, rk_valid=1. If rk is still held (rk_valid && !rk_ready), the step stalls: no emit, no shift.
    - After the group for round 0 is loaded, go to DRAIN.
  - DRAIN: hold until round 0 is handshaken, then go to IDLE.
- Handshake:
  - Transfer occurs when rk_valid&&rk_ready. rk_valid drops the cycle after transfer unless a new group loads in the same cycle.
  - rk, rk_round and rk_last are stable while rk_valid && !rk_ready.
  - key is sampled only on its handshake; key_valid outside IDLE is ignored.
- Reset: all outputs 0 (key_ready=0 during rst, 1 the cycle after); state IDLE; window and collector cleared.
  - rst mid-FWD/BWD/DRAIN aborts at once. Any pending rk is discarded, with no further rk_valid.
- NK values other than 4/6/8 are unsupported; elaboration must fail.

## Timing
- Key handshake at cycle 0. FWD occupies cycles 1..F, with F = 4(Nr+1)-NK: 40, 46 or 52.
- With rk_ready held high:
  - Round Nr is valid at cycle F+4.
  - Each subsequent round follows 4 cycles later.
  - Round 0 is valid at cycle F+4(Nr+1).
- key_ready returns high the cycle after the round-0 transfer.
- Back-pressure only adds stall cycles; outputs are order- and value-identical.
- SBox/RCon are read combinationally. They must be stable from key handshake until the round-0 transfer.

## Test plan
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> first rk = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_round=10 at cycle 44; last rk = the key, rk_round=0, rk_last=1 at cycle 84; 11 transfers total.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> first rk = e98ba06f448c773c8ecc720401002202, round 12; last rk = 8e73b0f7da0e6452c810f32b809079e5.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> first rk = fe4890d1e6188d0b046df344706c631e, round 14; round 1 = 1f352c073b6108d72d9810a30914dff4; round 0 = upper key half.
- NK=4, random rk_ready (about 30% duty) -> rk stable while stalled; the sequence equals the ready=1 run; no drops or duplicates.
- rst asserted for 1 cycle mid-BWD with rk_valid=1 -> next cycle rk_valid=0, key_ready=1. A new key then yields a correct full sequence.
- key_valid held high during FWD and BWD with a changing key -> ignored; outputs match the originally accepted key.

Source files
------------

// File: rtl/aes_kinv.sv
// aes_kinv: inverse-order AES key scheduler. It expands the cipher key forward
// through an NK-word window, then unwinds it to emit round keys Nr..0.
// Ports: clk/rst (sync, active-high); key_valid/key_ready/key: key intake;
//   SBox/RCon: lookup tables read combinationally;
//   rk_valid/rk_ready/rk/rk_round/rk_last: round-key output stream.
module aes_kinv #(
    parameter int NK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key,
    input  logic [7:0]   SBox [0:255],
    input  logic [7:0]   RCon [0:15],
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);
    localparam int NR = NK + 6;
    localparam logic [5:0] NKW  = 6'(NK);
    localparam logic [5:0] JTOP = 6'(4 * NR + 3);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_kinv: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, FWD, BWD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] win [0:NK-1];
    logic [95:0] col;
    logic [5:0]  j;
    logic        rk_vq;
    logic [31:0] gx, gval, nw;
    logic [5:0]  jm;
    logic [3:0]  jd;
    logic        xfer, grp, step, load;

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {SBox[x[31:24]], SBox[x[23:16]], SBox[x[15:8]], SBox[x[7:0]]};
    endfunction

    // One g() instance: forward uses the newest word, backward the one below it.
    always_comb begin
        gx   = (state == BWD) ? win[NK-2] : win[NK-1];
        jm   = j % NKW;
        jd   = 4'(j / NKW);
        gval = gx;
        if (jm == 6'd0)
            gval = subw({gx[23:0], gx[31:24]}) ^ {RCon[jd], 24'h0};
        else if (NK == 8 && jm == 6'd4)
            gval = subw(gx);
        nw = ((state == BWD) ? win[NK-1] : win[0]) ^ gval;
    end

    // A group-completing step must wait while the previous key is unaccepted.
    always_comb begin
        xfer = rk_vq && rk_ready;
        grp  = (j[1:0] == 2'd0);
        step = !(grp && rk_vq && !rk_ready);
        load = (state == BWD) && step && grp;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (key_valid) state_nx = FWD;
            FWD:     if (j == JTOP) state_nx = BWD;
            BWD:     if (load && j == 6'd0) state_nx = DRAIN;
            DRAIN:   if (xfer) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) win[k] <= '0;
            col      <= '0;
            j        <= '0;
            rk       <= '0;
            rk_round <= '0;
            rk_vq    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (key_valid) begin
                    for (int k = 0; k < NK; k++)
                        win[k] <= key[255-32*k -: 32];
                    j <= NKW;
                end
                FWD: begin
                    for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
                    win[NK-1] <= nw;
                    if (j != JTOP) j <= j + 6'd1;
                end
                BWD: if (step) begin
                    for (int k = 1; k < NK; k++) win[k] <= win[k-1];
                    // Below index NK there is nothing left to reconstruct.
                    win[0] <= (j >= NKW) ? nw : 32'h0;
                    col    <= {win[NK-1], col[95:32]};
                    j      <= j - 6'd1;
                    if (grp) begin
                        rk       <= {win[NK-1], col};
                        rk_round <= j[5:2];
                    end
                end
                default: ;
            endcase
            if (load)      rk_vq <= 1'b1;
            else if (xfer) rk_vq <= 1'b0;
        end
    end

    assign key_ready = (state == IDLE) && !rst;
    assign rk_valid  = rk_vq && !rst;
    assign rk_last   = rk_valid && (rk_round == 4'd0);

endmodule
